// File: rtl/soc_or1k_wb_pkg.sv
// soc_or1k_wb_pkg: Wishbone B3 cycle/burst encodings, RAM FSM states and burst address helper
package soc_or1k_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_BURST  = 2'd2
  } state_e;
  // Next word address of an incrementing burst; linear wrap at memory depth is applied by the caller
  function automatic logic [29:0] wb_next_adr(input logic [29:0] adr, input logic [1:0] bte);
    return bte == BTE_WRAP4  ? {adr[29:2], adr[1:0] + 2'd1} :
           bte == BTE_WRAP8  ? {adr[29:3], adr[2:0] + 3'd1} :
           bte == BTE_WRAP16 ? {adr[29:4], adr[3:0] + 4'd1} : adr + 30'd1;
  endfunction
endpackage

// File: rtl/soc_or1k_wb_ram_mem.sv
// soc_or1k_wb_ram_mem: synchronous word RAM with byte-lane writes and 1-cycle registered read
module soc_or1k_wb_ram_mem #(
  parameter int DEPTH = 8192,
  parameter int AWD   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic [3:0]     we,
  input  logic [AWD-1:0] waddr,
  input  logic [31:0]    wdata,
  input  logic [AWD-1:0] raddr,
  output logic [31:0]    rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] wmask, rdata_d, rdata_q;
  // Lane mask and read data, forwarding lanes being written to the same word this edge
  always_comb begin
    wmask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    rdata_d = waddr == raddr ? (mem[raddr] & ~wmask) | (wdata & wmask) : mem[raddr];
  end
  // Byte-masked word write and registered read port
  always_ff @(posedge clk) begin
    if (|we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/soc_or1k_wb_ram.sv
// soc_or1k_wb_ram: Wishbone B3 slave RAM with classic cycles, registered-feedback bursts and range error
module soc_or1k_wb_ram
  import soc_or1k_wb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 32'h00008000,
  parameter int          AW       = 32,
  parameter int          DW       = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o
);
  localparam int DEPTH = int'(MEM_SIZE / 4);
  localparam int WI = $clog2(DEPTH);
  localparam logic [AW-3:0] MASK = (AW-2)'(DEPTH - 1);
  state_e state_q, state_d;
  logic [AW-3:0] cur_q, cur_d, adr_w, nxt_w;
  logic ok_q, ok_d, inc_q, inc_d;
  logic req, in_rng, hit;
  logic [3:0] we;
  logic [DW-1:0] rdata;
  // Response: ACCESS replays the registered decision, BURST acks only a beat matching the prediction
  always_comb begin
    req = wb_cyc_i & wb_stb_i;
    adr_w = wb_adr_i[AW-1:2];
    in_rng = wb_adr_i < AW'(MEM_SIZE);
    nxt_w = (cur_q & ~MASK) | ((AW-2)'(wb_next_adr(30'(cur_q), wb_bte_i)) & MASK);
    hit = state_q == ST_BURST && req && adr_w == cur_q && (wb_cti_i == CTI_INC || wb_cti_i == CTI_EOB);
    wb_ack_o = state_q == ST_ACCESS ? ok_q : hit & in_rng;
    wb_err_o = state_q == ST_ACCESS ? !ok_q : hit & !in_rng;
    wb_dat_o = wb_ack_o ? rdata : '0;
    we = wb_ack_o && wb_we_i && !wb_rst_i ? wb_sel_i : 4'b0;
  end
  // Next state; cur_d is also the RAM read address so the next beat's data is ready one cycle later
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    ok_d = ok_q;
    inc_d = inc_q;
    if (state_q == ST_ACCESS) begin
      state_d = inc_q ? ST_BURST : ST_IDLE;
      cur_d = inc_q ? nxt_w : cur_q;
    end else if (state_q == ST_BURST && !wb_cyc_i) begin
      state_d = ST_IDLE;
    end else if (hit) begin
      state_d = wb_cti_i == CTI_EOB ? ST_IDLE : ST_BURST;
      cur_d = nxt_w;
    end else if (req) begin
      state_d = ST_ACCESS;
      cur_d = adr_w;
      ok_d = in_rng;
      inc_d = wb_cti_i == CTI_INC;
    end
  end
  // State registers; memory contents survive reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cur_q <= '0;
      ok_q <= 1'b0;
      inc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      ok_q <= ok_d;
      inc_q <= inc_d;
    end
  end
  soc_or1k_wb_ram_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (wb_clk_i),
    .we    (we),
    .waddr (cur_q[WI-1:0]),
    .wdata (wb_dat_i),
    .raddr (cur_d[WI-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_soc_or1k_wb_ram.sv
// tb_soc_or1k_wb_ram: directed and randomized Wishbone master against a word-array reference model
module tb_soc_or1k_wb_ram;
  localparam int unsigned MEM_SIZE = 32'h00008000;
  localparam int DEPTH = int'(MEM_SIZE / 4);
  logic clk = 0, rst = 1;
  logic [31:0] adr = 0, dat_i = 0, dat_o;
  logic [3:0] sel = 0;
  logic we = 0, cyc = 0, stb = 0, ack, err;
  logic [2:0] cti = 0;
  logic [1:0] bte = 0;
  int total = 0, passed = 0, fails = 0;
  logic [31:0] ref_mem [DEPTH];

  soc_or1k_wb_ram #(.MEM_SIZE(MEM_SIZE), .AW(32), .DW(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a < MEM_SIZE;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a % MEM_SIZE) / 4);
  endfunction

  // Burst successor: increment inside an aligned span (whole memory for linear, N words for wrap-N)
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] b);
    logic [31:0] span;
    span = b == 2'b00 ? MEM_SIZE : 32'd8 << b;
    return (a & ~(span - 1)) | ((a + 32'd4) & (span - 1));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  // Cycle in which no response may appear
  task automatic quiet(input string tag);
    #4;
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    tick();
  endtask

  // Cycle in which the transfer at address a must be answered
  task automatic resp(input string tag, input logic [31:0] a);
    #4;
    chk({tag, "_ack"}, 32'(ack), 32'(in_rng(a)));
    chk({tag, "_err"}, 32'(err), 32'(!in_rng(a)));
    if (!in_rng(a)) chk({tag, "_dat0"}, dat_o, 32'd0);
    else if (!we) chk({tag, "_dat"}, dat_o, ref_mem[widx(a)]);
    if (we) model_write(a, dat_i, sel);
    tick();
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; cti = 3'b000;
    quiet("cls_req");
    resp("cls", a);
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0;
    quiet("idle");
  endtask

  task automatic burst(input logic w, input logic [31:0] a0, input logic [1:0] b, input int n);
    logic [31:0] a;
    a = a0;
    cyc = 1; stb = 1; we = w; bte = b; adr = a;
    cti = n == 1 ? 3'b111 : 3'b010;
    dat_i = $urandom; sel = w ? 4'($urandom) : 4'hf;
    quiet("bst_req");
    for (int k = 0; k < n; k++) begin
      resp("bst", a);
      if (k < n - 1) begin
        a = nxt(a, b);
        adr = a;
        cti = k == n - 2 ? 3'b111 : 3'b010;
        dat_i = $urandom; sel = w ? 4'($urandom) : 4'hf;
      end
    end
    idle();
  endtask

  initial begin
    cyc = 1; stb = 1; adr = 0;
    tick(); tick();
    #4;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst = 0; cyc = 0; stb = 0;
    tick();
    for (int i = 0; i < 64; i++) classic(1'b1, 32'(i * 4), 32'(i), 4'hf);
    idle();
    classic(1'b1, 32'h100, 32'hDEADBEEF, 4'hf);
    classic(1'b0, 32'h100, 32'h0, 4'hf);
    chk("raw_classic", ref_mem[64], 32'hDEADBEEF);
    classic(1'b1, 32'h100, 32'h000000AA, 4'b0001);
    classic(1'b0, 32'h100, 32'h0, 4'hf);
    chk("byte_lane_model", ref_mem[64], 32'hDEADBEAA);
    idle();
    burst(1'b0, 32'h10, 2'b00, 8);
    burst(1'b0, 32'h18, 2'b01, 4);
    cyc = 1; stb = 1; we = 0; bte = 2'b01; adr = 32'h18; cti = 3'b010;
    quiet("wrap_req");
    resp("wrap", 32'h18);
    adr = 32'h1C;
    resp("wrap", 32'h1C);
    adr = 32'h20;
    quiet("wrap_mismatch");
    resp("wrap_fresh", 32'h20);
    adr = 32'h24; cti = 3'b111;
    resp("wrap_cont", 32'h24);
    idle();
    classic(1'b1, MEM_SIZE + 32'h4, 32'h12345678, 4'hf);
    idle();
    classic(1'b0, 32'h4, 32'h0, 4'hf);
    idle();
    burst(1'b0, MEM_SIZE + 32'h8, 2'b00, 3);
    cyc = 1; stb = 1; we = 1; bte = 2'b00; adr = 32'h40; cti = 3'b010; dat_i = 32'hA0; sel = 4'hf;
    quiet("rstb_req");
    resp("rstb", 32'h40);
    adr = 32'h44; dat_i = 32'hA1;
    resp("rstb", 32'h44);
    adr = 32'h48; dat_i = 32'hA2; rst = 1;
    tick();
    rst = 0; cyc = 0; stb = 0; we = 0;
    quiet("rstb_after");
    for (int i = 0; i < 4; i++) classic(1'b0, 32'h40 + 32'(i * 4), 32'h0, 4'hf);
    idle();
    chk("rstb_model", ref_mem[18], 32'd18);
    repeat (30) begin
      logic [1:0] b;
      b = 2'($urandom);
      burst(1'($urandom), 32'(b == 2'b00 ? $urandom_range(0, 47) : $urandom_range(0, 63)) * 4,
            b, int'($urandom_range(1, 16)));
    end
    repeat (40) begin
      classic(1'($urandom), 32'($urandom_range(0, 63)) * 4, $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    for (int i = 0; i < 64; i++) classic(1'b0, 32'(i * 4), 32'h0, 4'hf);
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
